// File: rtl/bsg_div_iterative.sv
// Radix-2 restoring divider: signed/unsigned quotient and remainder with a
// fixed latency of width_p+3 cycles and RISC-V divide-by-zero/overflow results.
module bsg_div_iterative #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    output logic               ready_o,
    input  logic [width_p-1:0] dividend_i,
    input  logic [width_p-1:0] divisor_i,
    input  logic               signed_i,
    input  logic               v_i,
    output logic [width_p-1:0] quotient_o,
    output logic [width_p-1:0] remainder_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int cnt_w_lp = (width_p > 2) ? $clog2(width_p) : 1;

    typedef enum logic [2:0] {
        eIdle,
        ePre,
        eCal,
        eFix,
        eDone
    } state_e;

    state_e state_q, state_d;

    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic [width_p-1:0]  dvd_q, dvd_d;
    logic [width_p-1:0]  dvs_q, dvs_d;
    logic [width_p-1:0]  rem_q, rem_d;
    logic [width_p-1:0]  quo_q, quo_d;
    logic [width_p-1:0]  quot_q, quot_d;
    logic [width_p-1:0]  remo_q, remo_d;
    logic                sgn_q, sgn_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                ready_q, ready_d;
    logic                v_q, v_d;

    logic                dvd_neg, dvs_neg;
    logic [width_p:0]    shl, diff;
    logic [width_p-1:0]  qfix, rfix;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ready_d = ready_q;
        v_d     = v_q;

        dvd_neg = sgn_q & dvd_q[width_p-1];
        dvs_neg = sgn_q & dvs_q[width_p-1];
        // remainder stays below the divisor, so width_p+1 bits never overflow
        shl     = {rem_q, quo_q[width_p-1]};
        diff    = shl - {1'b0, dvs_q};
        qfix    = negq_q ? -quo_q : quo_q;
        rfix    = negr_q ? -rem_q : rem_q;

        unique case (state_q)
            eIdle: begin
                if (v_i) begin
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    sgn_d   = signed_i;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ePre;
                end
            end
            ePre: begin
                quo_d   = dvd_neg ? -dvd_q : dvd_q;
                dvs_d   = dvs_neg ? -dvs_q : dvs_q;
                rem_d   = '0;
                negq_d  = dvd_neg ^ dvs_neg;
                negr_d  = dvd_neg;
                zero_d  = (dvs_q == '0);
                ovf_d   = sgn_q
                        & (dvd_q == {1'b1, {(width_p-1){1'b0}}})
                        & (&dvs_q);
                state_d = eCal;
            end
            eCal: begin
                if (!diff[width_p]) begin
                    rem_d = diff[width_p-1:0];
                    quo_d = {quo_q[width_p-2:0], 1'b1};
                end else begin
                    rem_d = shl[width_p-1:0];
                    quo_d = {quo_q[width_p-2:0], 1'b0};
                end
                cnt_d = cnt_q + cnt_w_lp'(1);
                if (cnt_q == cnt_w_lp'(width_p-1)) begin
                    state_d = eFix;
                end
            end
            eFix: begin
                if (zero_q) begin
                    quot_d = '1;
                    remo_d = dvd_q;
                end else if (ovf_q) begin
                    quot_d = dvd_q;
                    remo_d = '0;
                end else begin
                    quot_d = qfix;
                    remo_d = rfix;
                end
                v_d     = 1'b1;
                state_d = eDone;
            end
            eDone: begin
                if (yumi_i) begin
                    v_d     = 1'b0;
                    ready_d = 1'b1;
                    state_d = eIdle;
                end
            end
            default: begin
                v_d     = 1'b0;
                ready_d = 1'b1;
                state_d = eIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= eIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            v_q     <= v_d;
        end
    end

    assign ready_o     = ready_q;
    assign v_o         = v_q;
    assign quotient_o  = quot_q;
    assign remainder_o = remo_q;

endmodule

// File: tb/tb_bsg_div_iterative.sv
// Scoreboard bench for bsg_div_iterative: 8- and 64-bit instances run in
// lockstep, results compared against a plain-arithmetic reference model.
module tb_bsg_div_iterative;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] a, b;
    logic        s;
    logic        v8, v64;
    logic        yumi8 = 1'b0, yumi64 = 1'b0;
    logic        rdy8, rdy64, vo8, vo64;
    logic [7:0]  quo8, rem8;
    logic [63:0] quo64, rem64;

    bsg_div_iterative #(.width_p(8)) u8 (
        .clk_i(clk), .reset_n_i(rst_n), .ready_o(rdy8),
        .dividend_i(a[7:0]), .divisor_i(b[7:0]), .signed_i(s), .v_i(v8),
        .quotient_o(quo8), .remainder_o(rem8), .v_o(vo8), .yumi_i(yumi8)
    );

    bsg_div_iterative #(.width_p(64)) u64 (
        .clk_i(clk), .reset_n_i(rst_n), .ready_o(rdy64),
        .dividend_i(a), .divisor_i(b), .signed_i(s), .v_i(v64),
        .quotient_o(quo64), .remainder_o(rem64), .v_o(vo64), .yumi_i(yumi64)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          acc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb64[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   hold_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: ordinary SV division plus the RISC-V corner cases
    function automatic void model(input int w, input logic [63:0] a0,
                                  input logic [63:0] b0, input bit sg,
                                  output logic [63:0] q, output logic [63:0] r);
        logic [63:0] m;
        longint      sa, sd;
        m  = (w == 64) ? '1 : 64'hFF;
        a0 = a0 & m;
        b0 = b0 & m;
        if (b0 == 0) begin
            q = m;
            r = a0;
        end else if (sg) begin
            if (w == 8) begin
                sa = longint'($signed(a0[7:0]));
                sd = longint'($signed(b0[7:0]));
            end else begin
                sa = $signed(a0);
                sd = $signed(b0);
            end
            if (w == 64 && a0 == 64'h8000_0000_0000_0000 && b0 == m) begin
                q = a0;
                r = 0;
            end else begin
                q = sa / sd;
                r = sa % sd;
            end
        end else begin
            q = a0 / b0;
            r = a0 % b0;
        end
        q = q & m;
        r = r & m;
    endfunction

    bit   got8 = 0, got64 = 0;
    int   h8, h64;
    exp_t e8, e64;

    always @(negedge clk) begin
        if (!rst_n) begin
            got8  = 0;
            yumi8 = 1'b0;
        end else if (yumi8) begin
            yumi8 = 1'b0;
            got8  = 0;
            chk("rdy_after_yumi8", 64'(rdy8), 1);
            chk("vo_after_yumi8", 64'(vo8), 0);
        end else if (vo8) begin
            if (!got8) begin
                got8 = 1;
                h8   = hold_req ? 20 : $urandom_range(0, 3);
                if (sb8.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexp8: result with empty scoreboard q=%h", quo8);
                    got8 = 0;
                    h8   = 0;
                end else begin
                    e8 = sb8.pop_front();
                    chk("lat8", 64'(cyc - e8.acc), 11);
                    if (e8.b != 0)
                        chk("inv8", 64'(8'(quo8 * e8.b[7:0] + rem8)), e8.a);
                end
            end
            if (got8) begin
                chk("quo8", 64'(quo8), e8.q);
                chk("rem8", 64'(rem8), e8.r);
                chk("busy8", 64'(rdy8), 0);
            end
            if (h8 == 0) yumi8 = 1'b1;
            else h8--;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            got64  = 0;
            yumi64 = 1'b0;
        end else if (yumi64) begin
            yumi64 = 1'b0;
            got64  = 0;
            chk("rdy_after_yumi64", 64'(rdy64), 1);
            chk("vo_after_yumi64", 64'(vo64), 0);
        end else if (vo64) begin
            if (!got64) begin
                got64 = 1;
                h64   = hold_req ? 20 : $urandom_range(0, 3);
                if (sb64.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexp64: result with empty scoreboard q=%h", quo64);
                    got64 = 0;
                    h64   = 0;
                end else begin
                    e64 = sb64.pop_front();
                    chk("lat64", 64'(cyc - e64.acc), 67);
                    if (e64.b != 0)
                        chk("inv64", quo64 * e64.b + rem64, e64.a);
                end
            end
            if (got64) begin
                chk("quo64", quo64, e64.q);
                chk("rem64", rem64, e64.r);
                chk("busy64", 64'(rdy64), 0);
            end
            if (h64 == 0) yumi64 = 1'b1;
            else h64--;
        end
    end

    task automatic issue(input logic [63:0] a0, input logic [63:0] b0,
                         input bit sg);
        exp_t        e;
        logic [63:0] q, r;
        int          n = 0;
        while (!(rdy8 && rdy64) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: rdy8=%0b rdy64=%0b want 1 1", rdy8, rdy64);
        end
        a   = a0;
        b   = b0;
        s   = sg;
        v8  = 1'b1;
        v64 = 1'b1;
        model(8, a0, b0, sg, q, r);
        e = '{a: a0 & 64'hFF, b: b0 & 64'hFF, q: q, r: r, acc: cyc};
        sb8.push_back(e);
        model(64, a0, b0, sg, q, r);
        e = '{a: a0, b: b0, q: q, r: r, acc: cyc};
        sb64.push_back(e);
        @(negedge clk);
        v8  = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb8.size() != 0 || sb64.size() != 0 || !rdy8 || !rdy64)
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: pending %0d/%0d want 0/0",
                     sb8.size(), sb64.size());
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_v8"}, 64'(vo8), 0);
        chk({nm, "_rdy8"}, 64'(rdy8), 1);
        chk({nm, "_q8"}, 64'(quo8), 0);
        chk({nm, "_r8"}, 64'(rem8), 0);
        chk({nm, "_v64"}, 64'(vo64), 0);
        chk({nm, "_rdy64"}, 64'(rdy64), 1);
        chk({nm, "_q64"}, quo64, 0);
        chk({nm, "_r64"}, rem64, 0);
    endtask

    function automatic logic [63:0] rnd();
        logic [63:0] x;
        x = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: x = 0;
            1: x = '1;
            2: x = 64'h8000_0000_0000_0000;
            3: x = 64'hFFFF_FFFF_FFFF_FF80;
            4: x = x >> $urandom_range(1, 63);
            5: x = -(x >> $urandom_range(40, 63));
            6: x = x >> $urandom_range(56, 63);
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v8    = 1'b0;
        v64   = 1'b0;
        a     = 0;
        b     = 0;
        s     = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(64'd200, 64'd7, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        issue(64'h1234, 64'd0, 1'b0);
        issue(64'h1234, 64'd0, 1'b1);
        issue(64'h8000_0000_0000_0000, '1, 1'b1);
        issue(64'h80, 64'hFF, 1'b1);
        drain();

        hold_req = 1'b1;
        issue(64'd12345, 64'd67, 1'b0);
        drain();
        hold_req = 1'b0;

        issue(64'd1000, 64'd7, 1'b0);
        repeat (2) @(negedge clk);
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        s   = 1'b1;
        v8  = 1'b1;
        v64 = 1'b1;
        repeat (3) @(negedge clk);
        v8  = 1'b0;
        v64 = 1'b0;
        drain();

        issue({$urandom, $urandom}, 64'd3, 1'b0);
        repeat (30) @(negedge clk);
        sb8.delete();
        sb64.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("midreset");
        issue(64'd100, 64'd10, 1'b0);
        drain();

        for (int i = 0; i < 500; i++) begin
            issue(rnd(), rnd(), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
